// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one registered broadcast per cycle from NUM_SRC single-entry holding registers.
// Define CDB_AGE_PRIO_EN for oldest-first (ROB age) selection; the default build is round robin.
module cdb_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int ROB_ADDR_W = 4,
    parameter int DATA_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [ROB_ADDR_W-1:0]         rob_head,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*ROB_ADDR_W-1:0] src_robnum,
    input  logic [NUM_SRC*DATA_W-1:0]     src_data,
    input  logic [NUM_SRC-1:0]            src_need_jump,
    input  logic [NUM_SRC*DATA_W-1:0]     src_true_pc,
    output logic                          cdb_valid,
    output logic [ROB_ADDR_W-1:0]         cdb_robnum,
    output logic [DATA_W-1:0]             cdb_data,
    output logic                          cdb_need_jump,
    output logic [DATA_W-1:0]             cdb_true_pc,
    output logic [2:0]                    cdb_src
);

    logic [NUM_SRC-1:0]    hold_v;
    logic [ROB_ADDR_W-1:0] hold_robnum  [NUM_SRC];
    logic [DATA_W-1:0]     hold_data    [NUM_SRC];
    logic [NUM_SRC-1:0]    hold_need_jump;
    logic [DATA_W-1:0]     hold_true_pc [NUM_SRC];

    logic [2:0]            rr_ptr;
    logic                  sel_any;
    logic [2:0]            sel_idx;
    logic [ROB_ADDR_W-1:0] sel_robnum;
    logic [DATA_W-1:0]     sel_data;
    logic                  sel_need_jump;
    logic [DATA_W-1:0]     sel_true_pc;
    int                    key;
    int                    best_key;

    logic                  grant_any;
    logic [NUM_SRC-1:0]    grant;
    logic [NUM_SRC-1:0]    accept;

`ifdef CDB_AGE_PRIO_EN
    logic [ROB_ADDR_W-1:0] age;
    logic                  unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr;
`else
    logic                  unused_rob_head;
    assign unused_rob_head = ^rob_head;
`endif

    // Smallest key among held entries wins; strict compare breaks ties toward the lowest index.
    always_comb begin
        sel_any       = 1'b0;
        sel_idx       = '0;
        sel_robnum    = '0;
        sel_data      = '0;
        sel_need_jump = 1'b0;
        sel_true_pc   = '0;
        key           = 0;
        best_key      = 0;
`ifdef CDB_AGE_PRIO_EN
        age           = '0;
`endif
        for (int i = 0; i < NUM_SRC; i++) begin
`ifdef CDB_AGE_PRIO_EN
            age = hold_robnum[i] - rob_head;
            key = int'(age);
`else
            key = i - int'(rr_ptr) - 1;
            if (key < 0) begin
                key = key + NUM_SRC;
            end
`endif
            if (hold_v[i] && (!sel_any || key < best_key)) begin
                sel_any       = 1'b1;
                best_key      = key;
                sel_idx       = 3'(i);
                sel_robnum    = hold_robnum[i];
                sel_data      = hold_data[i];
                sel_need_jump = hold_need_jump[i];
                sel_true_pc   = hold_true_pc[i];
            end
        end
    end

    always_comb begin
        grant     = '0;
        grant_any = sel_any && !flush;
        for (int i = 0; i < NUM_SRC; i++) begin
            grant[i] = grant_any && (sel_idx == 3'(i));
        end
    end

    assign src_ready = {NUM_SRC{!flush}} & (~hold_v | grant);
    assign accept    = src_valid & src_ready;

    // A granted slot may be refilled on the same edge, giving one result per cycle per source.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_v         <= '0;
            hold_need_jump <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                hold_robnum[i]  <= '0;
                hold_data[i]    <= '0;
                hold_true_pc[i] <= '0;
            end
            rr_ptr        <= 3'(NUM_SRC - 1);
            cdb_valid     <= 1'b0;
            cdb_robnum    <= '0;
            cdb_data      <= '0;
            cdb_need_jump <= 1'b0;
            cdb_true_pc   <= '0;
            cdb_src       <= '0;
        end else begin
            cdb_valid <= grant_any;
            if (grant_any) begin
                cdb_robnum    <= sel_robnum;
                cdb_data      <= sel_data;
                cdb_need_jump <= sel_need_jump;
                cdb_true_pc   <= sel_true_pc;
                cdb_src       <= sel_idx;
                rr_ptr        <= sel_idx;
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (flush) begin
                    hold_v[i] <= 1'b0;
                end else if (accept[i]) begin
                    hold_v[i]         <= 1'b1;
                    hold_robnum[i]    <= src_robnum[i*ROB_ADDR_W +: ROB_ADDR_W];
                    hold_data[i]      <= src_data[i*DATA_W +: DATA_W];
                    hold_need_jump[i] <= src_need_jump[i];
                    hold_true_pc[i]   <= src_true_pc[i*DATA_W +: DATA_W];
                end else if (grant[i]) begin
                    hold_v[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed stimulus pushes expected broadcasts, a negedge monitor pops and compares.
module tb_cdb_arbiter;

    typedef struct {
        logic [3:0]  robnum;
        logic [31:0] data;
        logic        need_jump;
        logic [31:0] true_pc;
        logic [2:0]  src;
    } bcast_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [3:0]  rob_head;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [11:0] src_robnum;
    logic [95:0] src_data;
    logic [2:0]  src_need_jump;
    logic [95:0] src_true_pc;
    logic        cdb_valid;
    logic [3:0]  cdb_robnum;
    logic [31:0] cdb_data;
    logic        cdb_need_jump;
    logic [31:0] cdb_true_pc;
    logic [2:0]  cdb_src;

    bcast_t exp_q[$];
    bcast_t mon_exp;
    int     vectors     = 0;
    int     miscompares = 0;

    cdb_arbiter #(.NUM_SRC(3), .ROB_ADDR_W(4), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .rob_head      (rob_head),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .src_robnum    (src_robnum),
        .src_data      (src_data),
        .src_need_jump (src_need_jump),
        .src_true_pc   (src_true_pc),
        .cdb_valid     (cdb_valid),
        .cdb_robnum    (cdb_robnum),
        .cdb_data      (cdb_data),
        .cdb_need_jump (cdb_need_jump),
        .cdb_true_pc   (cdb_true_pc),
        .cdb_src       (cdb_src)
    );

    always #5 clk = ~clk;

    function automatic bcast_t item(input int s, input int k);
        bcast_t p;
        p.robnum    = 4'(s * 2 + k + 1);
        p.data      = 32'(32'hA000_0000 + s * 256 + k);
        p.need_jump = (s == 2) && (k == 1);
        p.true_pc   = 32'(32'h1000 + s * 16 + k * 4);
        p.src       = 3'(s);
        return p;
    endfunction

    task automatic applyStimulus(input bcast_t p);
        int s;
        s = int'(p.src);
        src_valid[s]             = 1'b1;
        src_robnum[s*4 +: 4]     = p.robnum;
        src_data[s*32 +: 32]     = p.data;
        src_need_jump[s]         = p.need_jump;
        src_true_pc[s*32 +: 32]  = p.true_pc;
    endtask

    task automatic expect_bcast(input bcast_t p);
        exp_q.push_back(p);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Every broadcast must match the oldest outstanding expectation, including its source index.
    always @(negedge clk) begin
        if (rst === 1'b1 && cdb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_bcast: got src %0d robnum %0h, expected none", cdb_src, cdb_robnum);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("cdb_robnum", cdb_robnum, mon_exp.robnum);
                checkOutput("cdb_data", cdb_data, mon_exp.data);
                checkOutput("cdb_need_jump", cdb_need_jump, mon_exp.need_jump);
                checkOutput("cdb_true_pc", cdb_true_pc, mon_exp.true_pc);
                checkOutput("cdb_src", cdb_src, mon_exp.src);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        bcast_t p;
        rst = 1'b0;
        flush = 1'b0;
        rob_head = '0;
        src_valid = '0;
        src_robnum = '0;
        src_data = '0;
        src_need_jump = '0;
        src_true_pc = '0;

        #12;
        checkOutput("reset_cdb_valid", cdb_valid, 0);
        checkOutput("reset_cdb_src", cdb_src, 0);
        checkOutput("reset_src_ready", src_ready, 3'b111);
        next_cycle();
        rst = 1'b1;
        next_cycle();

        $display("[TB] round robin, all sources streaming");
        for (int s = 0; s < 3; s++) applyStimulus(item(s, 0));
        for (int s = 0; s < 3; s++) expect_bcast(item(s, 0));
        for (int s = 0; s < 3; s++) expect_bcast(item(s, 1));
        next_cycle();
        checkOutput("rr_ready_0", src_ready, 3'b001);
        checkOutput("rr_valid_pre", cdb_valid, 0);
        for (int s = 0; s < 3; s++) applyStimulus(item(s, 1));
        next_cycle();
        checkOutput("rr_valid", cdb_valid, 1);
        checkOutput("rr_ready_1", src_ready, 3'b010);
        src_valid[0] = 1'b0;
        next_cycle();
        checkOutput("rr_valid", cdb_valid, 1);
        checkOutput("rr_ready_2", src_ready, 3'b100);
        src_valid[1] = 1'b0;
        next_cycle();
        checkOutput("rr_valid", cdb_valid, 1);
        src_valid[2] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            checkOutput("rr_valid", cdb_valid, 1);
        end
        next_cycle();
        checkOutput("rr_valid_post", cdb_valid, 0);

        $display("[TB] backpressure on source 1");
        applyStimulus(item(0, 2));
        applyStimulus(item(1, 2));
        expect_bcast(item(0, 2));
        expect_bcast(item(1, 2));
        expect_bcast(item(1, 3));
        next_cycle();
        checkOutput("bp_ready_blocked", src_ready, 3'b101);
        src_valid[0] = 1'b0;
        applyStimulus(item(1, 3));
        next_cycle();
        checkOutput("bp_ready_granted", src_ready, 3'b111);
        checkOutput("bp_valid", cdb_valid, 1);
        next_cycle();
        src_valid[1] = 1'b0;
        checkOutput("bp_valid", cdb_valid, 1);
        next_cycle();
        checkOutput("bp_valid", cdb_valid, 1);
        next_cycle();
        checkOutput("bp_valid_post", cdb_valid, 0);

        $display("[TB] single ALU result latency and pulse width");
        p.robnum = 4'd5;
        p.data = 32'h1234;
        p.need_jump = 1'b0;
        p.true_pc = 32'h100;
        p.src = 3'd0;
        applyStimulus(p);
        expect_bcast(p);
        next_cycle();
        checkOutput("single_after_e0", cdb_valid, 0);
        src_valid[0] = 1'b0;
        next_cycle();
        checkOutput("single_after_e1", cdb_valid, 1);
        next_cycle();
        checkOutput("single_after_e2", cdb_valid, 0);

        $display("[TB] flush with held results and a new arrival");
        applyStimulus(item(0, 4));
        applyStimulus(item(1, 4));
        next_cycle();
        flush = 1'b1;
        src_valid = '0;
        applyStimulus(item(2, 4));
        #1;
        checkOutput("flush_ready", src_ready, 3'b000);
        next_cycle();
        checkOutput("flush_cdb_valid", cdb_valid, 0);
        flush = 1'b0;
        src_valid[2] = 1'b0;
        #1;
        checkOutput("flush_hold_cleared", src_ready, 3'b111);
        applyStimulus(item(1, 5));
        applyStimulus(item(2, 5));
        expect_bcast(item(1, 5));
        expect_bcast(item(2, 5));
        next_cycle();
        checkOutput("flush_post_valid", cdb_valid, 0);
        src_valid = '0;
        next_cycle();
        checkOutput("flush_post_valid", cdb_valid, 1);
        next_cycle();
        checkOutput("flush_post_valid", cdb_valid, 1);
        next_cycle();
        checkOutput("flush_post_idle", cdb_valid, 0);

        $display("[TB] reset with all sources held");
        for (int s = 0; s < 3; s++) applyStimulus(item(s, 6));
        next_cycle();
        src_valid = '0;
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst_cdb_valid", cdb_valid, 0);
        checkOutput("midrst_cdb_robnum", cdb_robnum, 0);
        checkOutput("midrst_cdb_data", cdb_data, 0);
        checkOutput("midrst_cdb_need_jump", cdb_need_jump, 0);
        checkOutput("midrst_cdb_true_pc", cdb_true_pc, 0);
        checkOutput("midrst_cdb_src", cdb_src, 0);
        next_cycle();
        rst = 1'b1;
        #1;
        checkOutput("midrst_src_ready", src_ready, 3'b111);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            checkOutput("midrst_no_stale", cdb_valid, 0);
        end

        $display("[TB] ROB-age ordering with head wrap");
        rob_head = 4'd14;
        for (int s = 0; s < 3; s++) begin
            p.robnum = (s == 0) ? 4'd1 : (s == 1) ? 4'd15 : 4'd3;
            p.data = 32'(32'hC000_0000 + s);
            p.need_jump = (s == 1);
            p.true_pc = 32'(32'h2000 + s);
            p.src = 3'(s);
            applyStimulus(p);
        end
`ifdef CDB_AGE_PRIO_EN
        expect_bcast('{4'd15, 32'hC000_0001, 1'b1, 32'h2001, 3'd1});
        expect_bcast('{4'd1,  32'hC000_0000, 1'b0, 32'h2000, 3'd0});
        expect_bcast('{4'd3,  32'hC000_0002, 1'b0, 32'h2002, 3'd2});
`else
        expect_bcast('{4'd1,  32'hC000_0000, 1'b0, 32'h2000, 3'd0});
        expect_bcast('{4'd15, 32'hC000_0001, 1'b1, 32'h2001, 3'd1});
        expect_bcast('{4'd3,  32'hC000_0002, 1'b0, 32'h2002, 3'd2});
`endif
        next_cycle();
        src_valid = '0;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            checkOutput("age_valid", cdb_valid, 1);
        end
        next_cycle();
        checkOutput("age_idle", cdb_valid, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) next_cycle();
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Schedules the single result/broadcast port into the reorder buffer among several completion sources: ALU, load/store buffer, branch unit.
- Each source owns a 1-entry holding register with a valid/ready handshake.
- One winner per cycle is driven onto a registered common data bus (CDB). The ROB and reservation stations consume the CDB.
- Sits between the functional units and the ROB write/wakeup port. Clears all in-flight results on a misbranch flush.

Parameters:
- NUM_SRC, 3, number of completion sources (index 0 = ALU, 1 = SLB, 2 = branch unit); legal range 2..8.
- ROB_ADDR_W, 4, ROB index width.
- DATA_W, 32, result data and PC width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  misbranch flush from the ROB; active high, sampled at posedge.
- rob_head  in  ROB_ADDR_W  current ROB head index; used only by the optional feature.
- src_valid  in  NUM_SRC  per-source result valid.
- src_ready  out  NUM_SRC  per-source accept, combinational.
- src_robnum  in  NUM_SRC*ROB_ADDR_W  per-source ROB index, packed with source i at bits [i*W +: W].
- src_data  in  NUM_SRC*DATA_W  per-source result value, packed.
- src_need_jump  in  NUM_SRC  per-source resolved branch direction.
- src_true_pc  in  NUM_SRC*DATA_W  per-source resolved target PC, packed.
- cdb_valid  out  1  broadcast valid, registered.
- cdb_robnum  out  ROB_ADDR_W  broadcast ROB index.
- cdb_data  out  DATA_W  broadcast value.
- cdb_need_jump  out  1  broadcast branch direction.
- cdb_true_pc  out  DATA_W  broadcast target PC.
- cdb_src  out  3  index of the winning source, for debug and perf.

Behaviour:
- Reset (rst=0, async):
  - all hold_v = 0; rr_ptr = NUM_SRC-1, so source 0 has first priority.
  - cdb_valid = 0; cdb_robnum, cdb_data, cdb_need_jump, cdb_true_pc, cdb_src = 0.
  - Reset mid-transfer discards all held results.
- Holding register per source: hold_v, robnum, data, need_jump, true_pc.
- Handshake:
  - src_ready[i] = !flush && (!hold_v[i] || grant[i]).
  - A transfer occurs when src_valid[i] && src_ready[i]; the payload is captured at posedge and hold_v[i] is set.
  - Payload must stay stable while valid && !ready.
- Arbitration is combinational over hold_v only; there is no same-cycle bypass from src_* to cdb_*.
  - Default mode is round robin. Priority order is rr_ptr+1, rr_ptr+2, ... mod NUM_SRC.
  - At most one grant per cycle. rr_ptr is set to the granted index; it is unchanged when nothing is granted.
- On grant[i] at a posedge: the cdb_* registers load the hold i payload, cdb_valid=1, cdb_src=i. hold_v[i] clears unless the same edge accepts a new transfer from source i.
- With no grant: cdb_valid=0 next cycle; the cdb payload registers hold their last value.
- Latency:
  - Minimum 2 edges from acceptance to cdb_valid (accept at E0, broadcast after E1).
  - cdb_valid is a 1-cycle pulse per result.
  - Full throughput is 1 result/cycle aggregate and 1 result/cycle per source when that source wins every cycle.
- Flush (flush=1 at a posedge):
  - all hold_v = 0; cdb_valid = 0 next cycle; no grant is issued; rr_ptr is unchanged.
  - src_ready = 0 during the flush cycle, so nothing is accepted.
  - Flush takes priority over any simultaneous accept or grant.
- Starvation bound, round-robin mode: a held source is granted within NUM_SRC cycles.
- cdb_src is width 3 and zero-extended.

Optional Feature:
- Macro: CDB_AGE_PRIO_EN.
- Defined:
  - Arbitration is oldest-first. age_i = (hold_robnum_i - rob_head) mod 2^ROB_ADDR_W, smallest age wins.
  - Equal ages are broken by the lowest index.
  - rr_ptr is still updated but does not affect selection.
- Undefined: pure round robin as above, and rob_head is ignored (left unconnected internally).

Test Plan:
1. Reset: rst low mid-stream with hold_v=3'b111 -> all cdb_* = 0 and src_ready=3'b111 immediately after rst rises; no stale broadcast.
2. Single source: ALU valid, robnum=5, data=32'h1234 at E0 -> cdb_valid=1, cdb_robnum=5, cdb_data=32'h1234, cdb_src=0 after E1, pulse for exactly 1 cycle.
3. Round robin (feature off): all 3 sources held continuously, each re-sending when ready -> cdb_src sequence 0,1,2,0,1,2; no gaps in cdb_valid.
4. Backpressure: sources 0 and 1 held, source 0 wins, source 1 sends again -> src_ready[1]=0 until source 1 is granted; its payload is not overwritten.
5. Flush: hold_v=3'b011 and flush=1 together with src_valid[2]=1 -> next cycle cdb_valid=0 and hold_v=0; source 2's result is dropped.
6. Age priority (CDB_AGE_PRIO_EN): rob_head=14, held robnums are 1, 15, 3 -> grant order source 1 (age 1), source 0 (age 3), source 2 (age 5), with wrap-around verified.
